// File: rtl/bp_common_rv64_pkg.sv
// RV64 instruction layout, opcode constants and register-use descriptor
// shared by the issue scoreboard and its decode helper.
package bp_common_rv64_pkg;

  localparam int rv64_rf_els_gp = 32;

  localparam logic [6:0] rv64_opcode_lui       = 7'b0110111;
  localparam logic [6:0] rv64_opcode_auipc     = 7'b0010111;
  localparam logic [6:0] rv64_opcode_jal       = 7'b1101111;
  localparam logic [6:0] rv64_opcode_jalr      = 7'b1100111;
  localparam logic [6:0] rv64_opcode_load      = 7'b0000011;
  localparam logic [6:0] rv64_opcode_op_imm    = 7'b0010011;
  localparam logic [6:0] rv64_opcode_op_imm32  = 7'b0011011;
  localparam logic [6:0] rv64_opcode_system    = 7'b1110011;
  localparam logic [6:0] rv64_opcode_branch    = 7'b1100011;
  localparam logic [6:0] rv64_opcode_store     = 7'b0100011;
  localparam logic [6:0] rv64_opcode_op        = 7'b0110011;
  localparam logic [6:0] rv64_opcode_op32      = 7'b0111011;
  localparam logic [6:0] rv64_opcode_amo       = 7'b0101111;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2_addr;
    logic [4:0] rs1_addr;
    logic [2:0] funct3;
    logic [4:0] rd_addr;
    logic [6:0] opcode;
  } rv64_instr_s;

  typedef struct packed {
    logic rs1_v;
    logic rs2_v;
    logic rd_v;
  } bp_be_reg_use_s;

endpackage

// File: rtl/bp_be_issue_scoreboard_if.sv
// Handshake bundle of the issue scoreboard: front-end enqueue, backend
// issue (valid/yumi) and writeback. The slave modport is the scoreboard side,
// the master modport is the surrounding pipeline (or a bench).
interface bp_be_issue_scoreboard_if;
  import bp_common_rv64_pkg::*;

  rv64_instr_s instr_i;
  logic        instr_v_i;
  logic        instr_ready_o;
  rv64_instr_s issue_instr_o;
  logic        issue_v_o;
  logic        issue_yumi_i;
  logic        wb_v_i;
  logic [4:0]  wb_rd_addr_i;

  modport slave (
    input  instr_i, instr_v_i, issue_yumi_i, wb_v_i, wb_rd_addr_i,
    output instr_ready_o, issue_instr_o, issue_v_o
  );

  modport master (
    output instr_i, instr_v_i, issue_yumi_i, wb_v_i, wb_rd_addr_i,
    input  instr_ready_o, issue_instr_o, issue_v_o
  );

endinterface

// File: rtl/bp_be_instr_reg_use.sv
// Combinational decode of which architectural registers an RV64 instruction
// reads (rs1/rs2) and writes (rd), from its major opcode only.
// Ports: instr_i (raw instruction) -> reg_use_o {rs1_v, rs2_v, rd_v}.
module bp_be_instr_reg_use
  import bp_common_rv64_pkg::*;
(
  input  rv64_instr_s    instr_i,
  output bp_be_reg_use_s reg_use_o
);

  // Only the opcode matters here; the other fields are consumed elsewhere.
  logic unused_fields;
  assign unused_fields = ^{instr_i.funct7, instr_i.rs2_addr, instr_i.rs1_addr,
                           instr_i.funct3, instr_i.rd_addr};

  always_comb begin
    reg_use_o = '0;
    case (instr_i.opcode)
      rv64_opcode_lui, rv64_opcode_auipc, rv64_opcode_jal:
        reg_use_o = '{rs1_v: 1'b0, rs2_v: 1'b0, rd_v: 1'b1};
      rv64_opcode_jalr, rv64_opcode_load, rv64_opcode_op_imm,
      rv64_opcode_op_imm32, rv64_opcode_system:
        reg_use_o = '{rs1_v: 1'b1, rs2_v: 1'b0, rd_v: 1'b1};
      rv64_opcode_branch, rv64_opcode_store:
        reg_use_o = '{rs1_v: 1'b1, rs2_v: 1'b1, rd_v: 1'b0};
      rv64_opcode_op, rv64_opcode_op32, rv64_opcode_amo:
        reg_use_o = '{rs1_v: 1'b1, rs2_v: 1'b1, rd_v: 1'b1};
      default: reg_use_o = '0;
    endcase
  end

endmodule

// File: rtl/bp_be_issue_scoreboard.sv
// Single-issue in-order scheduler: a small instruction queue whose head is
// released only when none of its used registers (rs1, rs2, rd) is busy.
// Issuing a nonzero-rd writer marks rd busy; writeback clears it.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   io (slave)     : enqueue (instr/v/ready), issue (instr/v/yumi), writeback
//   flush_i        : drop all queued instructions (scoreboard kept)
//   busy_o         : current busy bit per register
// Build option: BP_ISSUE_WB_BYPASS_EN lets a same-cycle writeback mask its
// busy bit in the hazard check (combinational wb -> issue_v_o path).
module bp_be_issue_scoreboard
  import bp_common_rv64_pkg::*;
#(
  parameter int fifo_els_p = 4,
  parameter int rf_els_p   = rv64_rf_els_gp
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_be_issue_scoreboard_if.slave io,
  input  logic                  flush_i,
  output logic [rf_els_p-1:0]   busy_o
);

  localparam int ptr_w = $clog2(fifo_els_p);

  rv64_instr_s          mem [fifo_els_p];
  logic [ptr_w-1:0]     rptr, wptr;
  logic [ptr_w:0]       count;
  logic [rf_els_p-1:0]  busy_r, busy_n, busy_chk;
  rv64_instr_s          head;
  bp_be_reg_use_s       head_use;
  logic                 hazard, enq, deq, full;

  assign head = mem[rptr];

  bp_be_instr_reg_use u_reg_use (
    .instr_i   (head),
    .reg_use_o (head_use)
  );

  // Ready comes from registered occupancy only; forced low during reset.
  assign full             = (count == (ptr_w+1)'(fifo_els_p));
  assign io.instr_ready_o = ~full & ~reset_i;

`ifdef BP_ISSUE_WB_BYPASS_EN
  assign busy_chk = busy_r & ~({rf_els_p{io.wb_v_i}} & (rf_els_p'(1) << io.wb_rd_addr_i));
`else
  assign busy_chk = busy_r;
`endif

  // busy[0] is held at 0, so x0 operands never cause a stall.
  assign hazard = (head_use.rs1_v & busy_chk[head.rs1_addr])
                | (head_use.rs2_v & busy_chk[head.rs2_addr])
                | (head_use.rd_v  & busy_chk[head.rd_addr]);

  assign io.issue_v_o     = (count != '0) & ~hazard & ~flush_i;
  assign io.issue_instr_o = head;

  assign enq = io.instr_v_i & io.instr_ready_o & ~flush_i;
  assign deq = io.issue_yumi_i & io.issue_v_o;

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= io.instr_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      rptr  <= wptr;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      count <= count + (ptr_w+1)'(enq) - (ptr_w+1)'(deq);
    end
  end

  // Clear first, then set, so an issue beats a same-cycle writeback.
  always_comb begin
    busy_n = busy_r;
    if (io.wb_v_i) busy_n[io.wb_rd_addr_i] = 1'b0;
    if (deq && head_use.rd_v) busy_n[head.rd_addr] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) busy_r <= '0;
    else         busy_r <= busy_n;
  end

  assign busy_o = busy_r;

endmodule

// File: tb/tb_bp_be_issue_scoreboard.sv
module tb_bp_be_issue_scoreboard;
  import bp_common_rv64_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic [31:0] busy_o;
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_instr;

  bp_be_issue_scoreboard_if sif();

  bp_be_issue_scoreboard #(.fifo_els_p(4), .rf_els_p(32)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .io      (sif.slave),
    .flush_i (flush_i),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // End the current cycle: let the posedge commit, then return all inputs
  // to idle at the following negedge.
  task automatic cycle();
    @(negedge clk);
    sif.instr_v_i    = 1'b0;
    sif.instr_i      = '0;
    sif.issue_yumi_i = 1'b0;
    sif.wb_v_i       = 1'b0;
    sif.wb_rd_addr_i = '0;
    flush_i          = 1'b0;
  endtask

  task automatic enqueue(input string tag, input logic [31:0] ins);
    #1 check({tag, "_ready"}, 32'(sif.instr_ready_o), 32'd1);
    sif.instr_v_i = 1'b1;
    sif.instr_i   = ins;
    exp_q.push_back(ins);
    cycle();
  endtask

  task automatic issue(input string tag, input logic wb_v, input logic [4:0] wb_rd);
    sif.issue_yumi_i = 1'b1;
    sif.wb_v_i       = wb_v;
    sif.wb_rd_addr_i = wb_rd;
    #1 check({tag, "_v"}, 32'(sif.issue_v_o), 32'd1);
    exp_instr = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hdeadbeef;
    check({tag, "_instr"}, sif.issue_instr_o, exp_instr);
    cycle();
  endtask

  task automatic writeback(input logic [4:0] rd);
    sif.wb_v_i       = 1'b1;
    sif.wb_rd_addr_i = rd;
    cycle();
  endtask

  initial begin
    reset_i = 1'b1;
    flush_i = 1'b0;
    sif.instr_v_i = 1'b0; sif.instr_i = '0; sif.issue_yumi_i = 1'b0;
    sif.wb_v_i = 1'b0; sif.wb_rd_addr_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(sif.instr_ready_o), 32'd0);
    check("rst_issue_v", 32'(sif.issue_v_o), 32'd0);
    check("rst_busy", busy_o, 32'd0);
    reset_i = 1'b0;

    // ADD x3,x1,x2 issues the cycle after enqueue and marks x3 busy.
    #1 check("empty_issue_v", 32'(sif.issue_v_o), 32'd0);
    enqueue("add3", 32'h002081B3);
    issue("add3", 1'b0, 5'd0);
    #1 check("add3_busy", busy_o, 32'h8);

    // ADD x4,x3,x3 stalls on x3 until writeback.
    enqueue("add4", 32'h00318233);
    #1 check("raw_stall0", 32'(sif.issue_v_o), 32'd0);
    cycle();
    #1 check("raw_stall1", 32'(sif.issue_v_o), 32'd0);
    sif.wb_v_i = 1'b1; sif.wb_rd_addr_i = 5'd3;
`ifdef BP_ISSUE_WB_BYPASS_EN
    #1 check("raw_wb_cycle", 32'(sif.issue_v_o), 32'd1);
`else
    #1 check("raw_wb_cycle", 32'(sif.issue_v_o), 32'd0);
`endif
    cycle();
    #1 check("raw_wb_busy", busy_o, 32'h0);
    issue("add4", 1'b0, 5'd0);
    #1 check("add4_busy", busy_o, 32'h10);
    writeback(5'd4);

    // LUI x0 never sets a busy bit; an x0 reader is not stalled.
    enqueue("lui0", 32'h12345037);
    issue("lui0", 1'b0, 5'd0);
    #1 check("lui0_busy", busy_o, 32'h0);
    enqueue("add6", 32'h00000333);
    issue("add6", 1'b0, 5'd0);
    #1 check("add6_busy", busy_o, 32'h40);
    writeback(5'd6);

    // Fill the queue; one yumi frees a slot only on the next cycle. The
    // yumi of the rd=5 writer coincides with a wb of x5: the set wins.
    enqueue("f1", 32'h000002B3);
    enqueue("f2", 32'h000003B3);
    enqueue("f3", 32'h000001B3);
    enqueue("f4", 32'h0000000F);
    #1 check("full_ready", 32'(sif.instr_ready_o), 32'd0);
    sif.issue_yumi_i = 1'b1;
    #1 check("full_ready_yumi", 32'(sif.instr_ready_o), 32'd0);
    sif.issue_yumi_i = 1'b0;
    issue("f1", 1'b1, 5'd5);
    #1 check("set_wins_busy", busy_o, 32'h20);
    check("occ3_ready", 32'(sif.instr_ready_o), 32'd1);
    issue("f2", 1'b0, 5'd0);
    issue("f3", 1'b0, 5'd0);
    #1 check("pre_flush_busy", busy_o, 32'hA8);
    enqueue("f5", 32'h00000433);
    enqueue("f6", 32'h00000013);

    // Flush with 3 queued, together with yumi, wb x3 and an enqueue.
    flush_i = 1'b1;
    sif.issue_yumi_i = 1'b1;
    sif.wb_v_i = 1'b1; sif.wb_rd_addr_i = 5'd3;
    sif.instr_v_i = 1'b1; sif.instr_i = 32'h00000093;
    #1 check("flush_issue_v", 32'(sif.issue_v_o), 32'd0);
    cycle();
    exp_q.delete();
    #1 check("post_flush_issue_v", 32'(sif.issue_v_o), 32'd0);
    check("post_flush_busy", busy_o, 32'hA0);
    check("post_flush_ready", 32'(sif.instr_ready_o), 32'd1);
    cycle();
    #1 check("post_flush_drop", 32'(sif.issue_v_o), 32'd0);

    // Reset mid-operation clears queue and scoreboard.
    enqueue("pre_rst", 32'h000002B3);
    reset_i = 1'b1;
    #1 check("midrst_ready", 32'(sif.instr_ready_o), 32'd0);
    cycle();
    reset_i = 1'b0;
    exp_q.delete();
    #1 check("midrst_issue_v", 32'(sif.issue_v_o), 32'd0);
    check("midrst_busy", busy_o, 32'h0);
    check("midrst_ready_after", 32'(sif.instr_ready_o), 32'd1);

    // WAW: a second writer of x1 waits for the first to write back.
    enqueue("waw_a", 32'h000000B3);
    enqueue("waw_b", 32'h000000B3);
    issue("waw_a", 1'b0, 5'd0);
    #1 check("waw_busy", busy_o, 32'h2);
    check("waw_stall", 32'(sif.issue_v_o), 32'd0);
    writeback(5'd1);
    issue("waw_b", 1'b0, 5'd0);
    writeback(5'd1);
    #1 check("final_busy", busy_o, 32'h0);
    check("final_empty", 32'(sif.issue_v_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
